// File: rtl/led_uart_reporter.sv
// led_uart_reporter
//   Watches a 16-bit LED status word and reports it over a UART tx pin as a
//   six-character ASCII frame: four uppercase hex digits, CR, LF (8N1).
//   A report goes out when the word differs from the last reported value,
//   or when force_send asks for one. A force request that arrives while a
//   frame is in flight is remembered, and it is sent as soon as the line is
//   free. Several such requests are merged into a single frame.
//
// Parameters
//   CLK_DIV     clock cycles per UART bit (2..65535)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset, released synchronously
//   data_in     status word to report
//   force_send  single-cycle request to report data_in even if unchanged
//   tx          UART serial output, idles high
//   busy        high while a frame is in flight
//   frame_done  one-cycle pulse on the last cycle of the final stop bit
//
// Handshake: there is no valid/ready pair here. data_in is sampled only in
// IDLE, and force_send is accepted on any cycle (it starts a frame when idle
// and is held pending when busy). busy and frame_done are status outputs only.
module led_uart_reporter #(
  parameter int CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        force_send,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

  state_t      state, state_next;
  logic [15:0] baud_cnt, baud_next;
  logic [2:0]  bit_idx, bit_next;
  logic [2:0]  char_idx, char_next;
  logic [15:0] snap, snap_next;
  logic [15:0] last_sent, last_next;
  logic        force_pend, pend_next;
  logic        tx_next;
  logic        baud_end;
  logic        trigger;
  logic [7:0]  next_char;

  // ASCII for one hex nibble, uppercase letters.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Character char_idx of the frame for word w.
  function automatic logic [7:0] frame_char(input logic [2:0] idx,
                                            input logic [15:0] w);
    case (idx)
      3'd0:    return hex_ascii(w[15:12]);
      3'd1:    return hex_ascii(w[11:8]);
      3'd2:    return hex_ascii(w[7:4]);
      3'd3:    return hex_ascii(w[3:0]);
      3'd4:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign baud_end = (baud_cnt == BAUD_MAX);
  assign trigger  = (data_in != last_sent) | force_send | force_pend;

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    char_next  = char_idx;
    snap_next  = snap;
    last_next  = last_sent;
    pend_next  = force_pend;

    case (state)
      IDLE: begin
        baud_next = '0;
        if (trigger) begin
          // A force_send in this cycle is covered by the frame started now,
          // so it does not leave a pending request behind.
          state_next = START;
          snap_next  = data_in;
          last_next  = data_in;
          pend_next  = 1'b0;
          bit_next   = '0;
          char_next  = '0;
        end
      end
      START: begin
        pend_next = force_pend | force_send;
        baud_next = baud_end ? 16'd0 : baud_cnt + 16'd1;
        if (baud_end) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        pend_next = force_pend | force_send;
        baud_next = baud_end ? 16'd0 : baud_cnt + 16'd1;
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // The frame_done cycle falls in here too, so a force on that cycle
        // is held as pending and produces one more frame.
        pend_next = force_pend | force_send;
        baud_next = baud_end ? 16'd0 : baud_cnt + 16'd1;
        if (baud_end) begin
          if (char_idx < 3'd5) begin
            state_next = START;
            char_next  = char_idx + 3'd1;
          end else begin
            state_next = IDLE;
            char_next  = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the next-state values so the pin never glitches
  // and still changes on the same edge as the state.
  always_comb begin
    next_char = frame_char(char_next, snap_next);
    tx_next   = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = next_char[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      snap       <= '0;
      last_sent  <= '0;
      force_pend <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      char_idx   <= char_next;
      snap       <= snap_next;
      last_sent  <= last_next;
      force_pend <= pend_next;
      tx         <= tx_next;
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && baud_end && (char_idx == 3'd5);

endmodule

// File: tb/tb_led_uart_reporter.sv
// tb_led_uart_reporter
//   Directed bench for led_uart_reporter. u1 runs with CLK_DIV=4 and u2 runs
//   with CLK_DIV=2. Both share clk and rst_n. Frames are captured one sample
//   per cycle, then decoded at bit centres and compared with hand-derived
//   ASCII.
module tb_led_uart_reporter;

  localparam int D1 = 4;
  localparam int D2 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data1, data2;
  logic        force1, force2;
  logic        tx1, busy1, fd1;
  logic        tx2, busy2, fd2;

  int checks   = 0;
  int failures = 0;

  // Capture buffer for one frame, one sample per cycle.
  logic rec_tx [0:299];
  int   rec_busy, rec_fd, rec_fd_pos, rec_wait;
  logic rec_found, rec_after_tx, rec_after_busy;

  always #5 clk = ~clk;

  led_uart_reporter #(.CLK_DIV(D1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .force_send(force1),
    .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  led_uart_reporter #(.CLK_DIV(D2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(data2), .force_send(force2),
    .tx(tx2), .busy(busy2), .frame_done(fd2)
  );

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  function automatic logic get_fd(input int sel);
    return (sel == 0) ? fd1 : fd2;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [47:0] exp_frame(input logic [15:0] w);
    return {hex_ascii(w[15:12]), hex_ascii(w[11:8]), hex_ascii(w[7:4]),
            hex_ascii(w[3:0]), 8'h0D, 8'h0A};
  endfunction

  // Decodes six characters from the capture buffer, sampling each bit at its centre.
  function automatic logic [47:0] rec_frame(input int d);
    logic [47:0] f;
    f = '0;
    for (int c = 0; c < 6; c++)
      for (int k = 0; k < 8; k++)
        f[(5-c)*8 + k] = rec_tx[c*10*d + (1+k)*d + d/2];
    return f;
  endfunction

  // Returns 1 when every start bit reads 0 and every stop bit reads 1.
  function automatic logic rec_framing(input int d);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (rec_tx[c*10*d + d/2] !== 1'b0) ok = 1'b0;
      if (rec_tx[c*10*d + 9*d + d/2] !== 1'b1) ok = 1'b0;
    end
    return ok;
  endfunction

  // ---------------- driver tasks ----------------

  task automatic wait_tx_low(input int sel, input int budget,
                             output logic found, output int waited);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      if (get_tx(sel) === 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
  endtask

  // Waits (bounded) for a start bit, then captures 60*d cycles of the frame.
  task automatic record(input int sel, input int d, input int budget);
    for (int i = 0; i < 300; i++) rec_tx[i] = 1'bx;
    rec_busy = 0; rec_fd = 0; rec_fd_pos = -1;
    rec_after_tx = 1'bx; rec_after_busy = 1'bx;
    wait_tx_low(sel, budget, rec_found, rec_wait);
    if (rec_found) begin
      for (int i = 0; i < 60*d; i++) begin
        rec_tx[i] = get_tx(sel);
        if (get_busy(sel) === 1'b1) rec_busy++;
        if (get_fd(sel) === 1'b1) begin
          rec_fd++;
          rec_fd_pos = i;
        end
        @(negedge clk);
      end
      rec_after_tx   = get_tx(sel);
      rec_after_busy = get_busy(sel);
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; data1 = 16'h1234; data2 = 16'h0000;
    force1 = 1'b0; force2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || fd1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: tx=%b busy=%b fd=%b, want tx=1 busy=0 fd=0", tx1, busy1, fd1);
    end
    data1 = 16'h0000;
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_silence: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] wave;
    int bad;
    data1 = 16'hA5F0;
    @(negedge clk);
    checks++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: tx=%b busy=%b, want tx=0 busy=1", tx1, busy1);
    end
    record(0, D1, 5);
    checks++;
    if (rec_frame(D1) !== 48'h41_35_46_30_0D_0A) begin
      failures++;
      $display("FAIL single_bytes: got %h want 413546300d0a", rec_frame(D1));
    end
    wave = {1'b1, 8'h41, 1'b0};
    bad = 0;
    for (int i = 0; i < 40; i++) if (rec_tx[i] !== wave[i/4]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_wave: %0d wrong samples in first char, want 0", bad);
    end
    checks++;
    if (rec_busy != 240 || rec_after_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy: %0d cycles then %b, want 240 then 0", rec_busy, rec_after_busy);
    end
    checks++;
    if (rec_fd != 1 || rec_fd_pos != 239) begin
      failures++;
      $display("FAIL single_frame_done: count=%0d pos=%0d, want 1 at 239", rec_fd, rec_fd_pos);
    end
    checks++;
    if (rec_framing(D1) !== 1'b1 || rec_after_tx !== 1'b1) begin
      failures++;
      $display("FAIL single_framing: framing=%b idle_tx=%b, want 1 1", rec_framing(D1), rec_after_tx);
    end
  endtask

  task automatic test_coalesce();
    logic found;
    int waited;
    data1 = 16'h0001;
    fork
      record(0, D1, 5);
      begin
        logic f;
        int w;
        wait_tx_low(0, 5, f, w);
        repeat (50) @(negedge clk);
        data1 = 16'h0002;
        repeat (50) @(negedge clk);
        data1 = 16'h0003;
      end
    join
    checks++;
    if (rec_frame(D1) !== exp_frame(16'h0001)) begin
      failures++;
      $display("FAIL coalesce_first: got %h want %h", rec_frame(D1), exp_frame(16'h0001));
    end
    record(0, D1, 5);
    checks++;
    if (rec_frame(D1) !== exp_frame(16'h0003) || rec_wait != 1) begin
      failures++;
      $display("FAIL coalesce_final: got %h gap=%0d want %h gap=1", rec_frame(D1), rec_wait, exp_frame(16'h0003));
    end
    wait_tx_low(0, 100, found, waited);
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL coalesce_no_extra: frame seen after %0d cycles, want none", waited);
    end
  endtask

  task automatic test_force_repeat();
    logic found;
    int waited;
    data1 = 16'hFFFF;
    fork
      record(0, D1, 5);
      begin
        logic f;
        int w;
        wait_tx_low(0, 5, f, w);
        repeat (20) @(negedge clk);
        force1 = 1'b1; @(negedge clk); force1 = 1'b0;
        repeat (79) @(negedge clk);
        force1 = 1'b1; @(negedge clk); force1 = 1'b0;
      end
    join
    checks++;
    if (rec_frame(D1) !== exp_frame(16'hFFFF)) begin
      failures++;
      $display("FAIL force_base: got %h want %h", rec_frame(D1), exp_frame(16'hFFFF));
    end
    // Second frame: the two busy-time pulses produce only this one frame.
    // A pulse on its frame_done cycle asks for a third frame.
    fork
      record(0, D1, 5);
      begin
        logic f;
        int w;
        wait_tx_low(0, 5, f, w);
        repeat (239) @(negedge clk);
        force1 = 1'b1; @(negedge clk); force1 = 1'b0;
      end
    join
    checks++;
    if (rec_frame(D1) !== exp_frame(16'hFFFF) || rec_wait != 1) begin
      failures++;
      $display("FAIL force_pending: got %h gap=%0d want %h gap=1", rec_frame(D1), rec_wait, exp_frame(16'hFFFF));
    end
    record(0, D1, 5);
    checks++;
    if (rec_frame(D1) !== exp_frame(16'hFFFF) || rec_wait != 1) begin
      failures++;
      $display("FAIL force_on_done: got %h gap=%0d want %h gap=1", rec_frame(D1), rec_wait, exp_frame(16'hFFFF));
    end
    wait_tx_low(0, 100, found, waited);
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL force_coalesced: extra frame after %0d cycles, want none", waited);
    end
    force1 = 1'b1; @(negedge clk); force1 = 1'b0;
    checks++;
    if (tx1 !== 1'b0) begin
      failures++;
      $display("FAIL force_idle_latency: tx=%b want 0", tx1);
    end
    record(0, D1, 2);
    checks++;
    if (rec_frame(D1) !== exp_frame(16'hFFFF)) begin
      failures++;
      $display("FAIL force_idle: got %h want %h", rec_frame(D1), exp_frame(16'hFFFF));
    end
    // A force that arrives together with a data change gives just one frame.
    data1 = 16'h1234; force1 = 1'b1; @(negedge clk); force1 = 1'b0;
    record(0, D1, 2);
    checks++;
    if (rec_frame(D1) !== exp_frame(16'h1234)) begin
      failures++;
      $display("FAIL force_absorbed: got %h want %h", rec_frame(D1), exp_frame(16'h1234));
    end
    wait_tx_low(0, 100, found, waited);
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL force_absorbed_extra: frame after %0d cycles, want none", waited);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic found;
    int waited;
    data1 = 16'h5555;
    wait_tx_low(0, 5, found, waited);
    // Offset 98 is the middle of DATA bit 3 of char 2. That char is '5' (0x35), so the line should be low there.
    repeat (98) @(negedge clk);
    checks++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: tx=%b busy=%b want tx=0 busy=1", tx1, busy1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
    data1 = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_tx_low(0, 100, found, waited);
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL midreset_silence: frame after %0d cycles, want none", waited);
    end
    data1 = 16'h7777;
    wait_tx_low(0, 5, found, waited);
    repeat (98) @(negedge clk);
    rst_n = 1'b0;
    data1 = 16'h00FF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    record(0, D1, 5);
    checks++;
    if (rec_frame(D1) !== exp_frame(16'h00FF) || rec_busy != 240) begin
      failures++;
      $display("FAIL midreset_fresh: got %h busy=%0d want %h busy=240", rec_frame(D1), rec_busy, exp_frame(16'h00FF));
    end
  endtask

  task automatic test_boundary();
    @(negedge clk);
    data2 = 16'h9A0F;
    record(1, D2, 5);
    checks++;
    if (rec_frame(D2) !== 48'h39_41_30_46_0D_0A) begin
      failures++;
      $display("FAIL div2_bytes: got %h want 394130460d0a", rec_frame(D2));
    end
    checks++;
    if (rec_busy != 120 || rec_after_busy !== 1'b0 || rec_fd != 1 || rec_fd_pos != 119) begin
      failures++;
      $display("FAIL div2_length: busy=%0d after=%b fd=%0d@%0d want 120 0 1@119", rec_busy, rec_after_busy, rec_fd, rec_fd_pos);
    end
    checks++;
    if (rec_framing(D2) !== 1'b1) begin
      failures++;
      $display("FAIL div2_framing: got %b want 1", rec_framing(D2));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_coalesce();
    test_force_repeat();
    test_reset_mid_frame();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_uart_reporter.md
Name: led_uart_reporter

Overview:
- Downstream consumer of the flip-flop test design's 16-bit LED status bus.
- Watches the bus and, whenever its value changes or a report is forced, serialises it as a 6-character ASCII frame: 4 uppercase hex digits, CR, LF.
- Output is the board's tx pin, 8N1 format, so hardware runs can be checked from a serial terminal rather than by inspecting LEDs.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  16  status word to report (led bus), synchronous to clk.
- force_send  in  1  single-cycle request to report data_in even if it is unchanged.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while a frame is in flight.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, frame_done=0, state=IDLE.
  - last_sent=16'h0000; force_pend=0; all counters 0.
  - Assertion mid-frame forces tx=1 immediately, with no partial stop bit.
- Trigger:
  - In IDLE, a trigger is (data_in != last_sent) OR force_send OR force_pend.
  - On the trigger cycle, capture snap=data_in, set last_sent=data_in, clear force_pend, and go to START.
  - tx falls on the first clock edge after the trigger cycle, i.e. latency 1.
- force_send while busy sets force_pend. It is serviced as soon as the current frame returns to IDLE. Multiple requests coalesce into one frame.
- Changes to data_in mid-frame are not sampled. After the frame ends, IDLE compares against last_sent, so only the final value is reported. Intermediate values are dropped by design.
- FSM states and transitions:
  - IDLE → START.
  - START (tx=0) → DATA.
  - DATA (8 bits, LSB first) → STOP.
  - STOP (tx=1) → START if char_idx<5, else IDLE.
  - Each state holds for exactly CLK_DIV cycles, counted by a baud counter from 0 to CLK_DIV-1 that resets on every state change.
  - There is no idle gap between characters.
- Frame length: 6 characters × 10 bits × CLK_DIV = 60·CLK_DIV cycles.
  - busy is high from the cycle after the trigger through the last STOP cycle.
  - frame_done pulses on that last STOP cycle.
  - A new frame may start on the next cycle. Back-to-back frames have tx=1 for exactly 1 cycle between the final stop bit and the next start bit.
- Character sequence, by char_idx:
  - 0: hex of snap[15:12].
  - 1: hex of snap[11:8].
  - 2: hex of snap[7:4].
  - 3: hex of snap[3:0].
  - 4: 8'h0D.
  - 5: 8'h0A.
- Hex encoding: nibble 0..9 → 8'h30+n; nibble 10..15 → 8'h41+(n-10), i.e. uppercase.
- Bit index (0..7) and char_idx (0..5) wrap to 0 at frame start. No other wrap-around cases exist.
- Simultaneous events:
  - force_send arriving in the same cycle as an IDLE trigger is absorbed by that frame; force_pend is not set.
  - force_send on the frame_done cycle sets force_pend, which causes one further frame.

Test Plan:
- Reset check (CLK_DIV=4): hold rst_n=0 with data_in=16'h1234 → tx=1, busy=0. Release with data_in=0 → no frame, tx stays 1 for 100 cycles.
- Single frame decode (CLK_DIV=4): set data_in=16'hA5F0 → tx falls 1 cycle later. Decoded bytes are 0x41,0x35,0x46,0x30,0x0D,0x0A. The first char on the wire is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles wide. busy lasts 240 cycles. One frame_done pulse.
- Coalescing: data_in=16'h0001, then mid-frame changes to 16'h0002 and then 16'h0003 → frame "0001\r\n" followed immediately by "0003\r\n". No "0002" frame is sent.
- Forced repeat: data_in stable at 16'hFFFF after its frame; pulse force_send twice while busy → exactly one extra "FFFF\r\n" frame. An idle force_send pulse → one more frame.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of char 2 → tx=1 in the same cycle, busy=0. After release with data_in=16'h0000 → silence. After release with data_in=16'h00FF → a fresh full "00FF\r\n" frame.
- Width/boundary: CLK_DIV=2, data_in=16'h9A0F → bytes 0x39,0x41,0x30,0x46,0x0D,0x0A. Frame length is exactly 120 cycles.
